// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store responder for a 256x16 RAM plus LED/switch/cycle-counter MMIO.
// Ports: clock/reset (sync, active-high); req_valid/req_ready/req_write/req_addr/req_wdata request channel;
// rsp_valid/rsp_rdata/rsp_err one-cycle response; sw_in switch inputs; ledr_out LED register.
module mem_responder #(
  parameter int WAIT_STATES = 1,
  parameter int SW_WIDTH = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_write,
  input  logic [15:0]         req_addr,
  input  logic [15:0]         req_wdata,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [15:0]         rsp_rdata,
  output logic                rsp_err,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [SW_WIDTH-1:0] ledr_out
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] wcnt;
  logic [15:0] cycles, cap_addr, cap_wdata, op_addr, op_wdata, rd;
  logic [15:0] ram [256];
  logic cap_write, op_write, commit, is_ram, is_led, is_sw, is_cnt;
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (req_valid ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE) :
              state == WAIT ? (wcnt == 4'd1 ? RESP : WAIT) : IDLE;
  always_comb begin
    req_ready = state == IDLE && !reset;
    rsp_valid = state == RESP;
  end
  // With no wait states the commit happens on the accept edge, so the live request is used directly.
  assign commit   = state_n == RESP;
  assign op_addr  = state == IDLE ? req_addr : cap_addr;
  assign op_write = state == IDLE ? req_write : cap_write;
  assign op_wdata = state == IDLE ? req_wdata : cap_wdata;
  assign is_ram   = op_addr[15:8] == 8'h00;
  assign is_led   = op_addr == 16'hFF00;
  assign is_sw    = op_addr == 16'hFF01;
  assign is_cnt   = op_addr == 16'hFF02;
  assign rd = op_write ? 16'h0000 :
              is_ram   ? ram[op_addr[7:0]] :
              is_led   ? 16'(ledr_out) :
              is_sw    ? 16'(sw_in) :
              is_cnt   ? cycles : 16'h0000;
  always_ff @(posedge clock)
    if (req_ready && req_valid) begin
      cap_addr  <= req_addr;
      cap_write <= req_write;
      cap_wdata <= req_wdata;
    end
  always_ff @(posedge clock) begin
    if (reset) begin
      cycles    <= '0;
      wcnt      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      ledr_out  <= '0;
    end else begin
      cycles <= cycles + 16'd1;
      wcnt   <= req_ready && req_valid ? 4'(WAIT_STATES) : state == WAIT ? wcnt - 4'd1 : wcnt;
      if (commit) begin
        rsp_rdata <= rd;
        rsp_err   <= !(is_ram || is_led || is_sw || is_cnt);
        if (op_write && is_led) ledr_out <= SW_WIDTH'(op_wdata);
      end
    end
  end
  always_ff @(posedge clock)
    if (!reset && commit && op_write && is_ram) ram[op_addr[7:0]] <= op_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of two mem_responder instances (1 and 0 wait states) against an edge-indexed model.
module tb_mem_responder;
  logic clock = 1'b0, reset = 1'b1;
  logic rv [2], rw [2], rdy [2], vld [2], er [2];
  logic [15:0] ra [2], rwd [2], rd [2];
  logic [9:0] sw, led [2];
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {int i; logic [15:0] d; logic e; int c;} rsp_t;
  rsp_t q [$];
  logic [15:0] pool [8] = '{16'h0000, 16'h0010, 16'h0042, 16'h007F, 16'h0080, 16'h00A5, 16'h00FF, 16'h0001};

  always #5 clock = ~clock;
  initial forever begin @(posedge clock); cyc++; end

  mem_responder #(.WAIT_STATES(1), .SW_WIDTH(10)) u0 (
    .clock(clock), .reset(reset), .req_valid(rv[0]), .req_write(rw[0]), .req_addr(ra[0]),
    .req_wdata(rwd[0]), .req_ready(rdy[0]), .rsp_valid(vld[0]), .rsp_rdata(rd[0]),
    .rsp_err(er[0]), .sw_in(sw), .ledr_out(led[0]));
  mem_responder #(.WAIT_STATES(0), .SW_WIDTH(10)) u1 (
    .clock(clock), .reset(reset), .req_valid(rv[1]), .req_write(rw[1]), .req_addr(ra[1]),
    .req_wdata(rwd[1]), .req_ready(rdy[1]), .rsp_valid(vld[1]), .rsp_rdata(rd[1]),
    .rsp_err(er[1]), .sw_in(sw), .ledr_out(led[1]));

  task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h", n, i, act, exp);
    end
  endtask

  // Model: edges are numbered; a request accepted at edge A commits at edge A+WS and
  // the next request can be accepted no earlier than edge A+WS+2.
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int WS = g == 0 ? 1 : 0;
    logic [15:0] ram [256];
    logic [9:0] led_m = '0;
    logic [15:0] xd = '0, pa = '0, pd = '0;
    logic xe = 1'b0, xv = 1'b0, pend = 1'b0, on = 1'b0, pw = 1'b0;
    int e = 0, r = 0, nxt = 0, c = 0;
    initial forever begin
      @(posedge clock);
      e++;
      xv = 1'b0;
      if (reset) begin
        on = 1'b1; r = e; nxt = e + 1; pend = 1'b0; led_m = '0; xd = '0; xe = 1'b0;
      end else begin
        if (e >= nxt && rv[g]) begin
          pend = 1'b1; c = e + WS; nxt = e + WS + 2; pw = rw[g]; pa = ra[g]; pd = rwd[g];
        end
        if (pend && e == c) begin
          pend = 1'b0;
          xv = 1'b1;
          xe = !(pa < 16'h0100 || pa == 16'hFF00 || pa == 16'hFF01 || pa == 16'hFF02);
          if (pw) xd = 16'h0000;
          else if (pa < 16'h0100) xd = ram[pa[7:0]];
          else if (pa == 16'hFF00) xd = {6'd0, led_m};
          else if (pa == 16'hFF01) xd = {6'd0, sw};
          else if (pa == 16'hFF02) xd = 16'(e - 1 - r);
          else xd = 16'h0000;
          if (pw && pa < 16'h0100) ram[pa[7:0]] = pd;
          if (pw && pa == 16'hFF00) led_m = pd[9:0];
        end
      end
    end
    initial forever begin
      @(negedge clock);
      if (on) begin
        chk("req_ready", g, 32'(rdy[g]), 32'(!reset && e + 1 >= nxt));
        chk("rsp_valid", g, 32'(vld[g]), 32'(xv));
        chk("rsp_rdata", g, 32'(rd[g]), 32'(xd));
        chk("rsp_err", g, 32'(er[g]), 32'(xe));
        chk("ledr_out", g, 32'(led[g]), 32'(led_m));
      end
      if (vld[g]) q.push_back('{i: g, d: rd[g], e: er[g], c: cyc});
    end
  end

  task automatic req(input int i, input logic w, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    rv[i] = 1'b1; rw[i] = w; ra[i] = a; rwd[i] = d;
    while (!rdy[i] && n < 50) begin @(negedge clock); n++; end
    if (!rdy[i]) begin
      checks++; errors++;
      $display("FAIL accept_timeout inst%0d got no req_ready want req_ready", i);
    end else @(negedge clock);
    rv[i] = 1'b0;
  endtask

  task automatic pop(output rsp_t s);
    int n = 0;
    while (q.size() == 0 && n < 20) begin @(negedge clock); n++; end
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL response_timeout got no rsp_valid want rsp_valid");
      s = '{i: -1, d: 16'hxxxx, e: 1'bx, c: 0};
    end else s = q.pop_front();
  endtask

  task automatic drain();
    repeat (6) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1);
  end

  initial begin
    rsp_t s1, s2, s3, s4;
    logic [15:0] a;
    int k;
    for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rwd[i] = '0; end
    sw = '0;
    repeat (3) @(negedge clock);
    chk("ready_in_reset", 0, 32'(rdy[0]), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 0, 32'(rdy[0]), 32'd1);
    chk("led_after_reset", 0, 32'(led[0]), 32'd0);
    chk("rdata_after_reset", 1, 32'(rd[1]), 32'd0);
    @(negedge clock);

    q.delete();
    req(0, 1'b1, 16'h0042, 16'hBEEF);
    req(0, 1'b0, 16'h0042, 16'h0000);
    drain();
    pop(s1); pop(s2);
    chk("store_rdata", 0, 32'(s1.d), 32'd0);
    chk("store_err", 0, 32'(s1.e), 32'd0);
    chk("load_rdata", 0, 32'(s2.d), 32'h0000BEEF);
    chk("ws1_spacing", 0, 32'(s2.c - s1.c), 32'd3);

    q.delete();
    req(0, 1'b1, 16'hFF00, 16'h03FF);
    drain();
    chk("led_store", 0, 32'(led[0]), 32'h3FF);
    req(0, 1'b0, 16'hFF00, 16'h0000);
    sw = 10'h155;
    req(0, 1'b0, 16'hFF01, 16'h0000);
    req(0, 1'b1, 16'hFF01, 16'h1234);
    drain();
    pop(s1); pop(s2); pop(s3); pop(s4);
    chk("led_load", 0, 32'(s2.d), 32'h03FF);
    chk("sw_load", 0, 32'(s3.d), 32'h0155);
    chk("sw_store_err", 0, 32'(s4.e), 32'd0);
    chk("led_unchanged", 0, 32'(led[0]), 32'h3FF);

    q.delete();
    req(0, 1'b1, 16'h0000, 16'h7777);
    req(0, 1'b1, 16'h0100, 16'h1234);
    req(0, 1'b0, 16'h0100, 16'h0000);
    req(0, 1'b0, 16'h0000, 16'h0000);
    drain();
    pop(s1); pop(s2); pop(s3); pop(s4);
    chk("unmapped_store_err", 0, 32'(s2.e), 32'd1);
    chk("unmapped_load_err", 0, 32'(s3.e), 32'd1);
    chk("unmapped_load_rdata", 0, 32'(s3.d), 32'd0);
    chk("ram0_kept", 0, 32'(s4.d), 32'h7777);

    req(1, 1'b1, 16'h0042, 16'hABCD);
    drain();
    q.delete();
    req(1, 1'b0, 16'hFF02, 16'h0000);
    req(1, 1'b0, 16'hFF02, 16'h0000);
    req(1, 1'b0, 16'h0042, 16'h0000);
    req(1, 1'b0, 16'hFF02, 16'h0000);
    drain();
    pop(s1); pop(s2); pop(s3); pop(s4);
    chk("b2b_gap1", 1, 32'(s2.c - s1.c), 32'd2);
    chk("b2b_gap2", 1, 32'(s3.c - s2.c), 32'd2);
    chk("b2b_gap3", 1, 32'(s4.c - s3.c), 32'd2);
    chk("counter_delta", 1, 32'(16'(s2.d - s1.d)), 32'd2);
    chk("b2b_ram", 1, 32'(s3.d), 32'h0000ABCD);
    chk("counter_delta2", 1, 32'(16'(s4.d - s2.d)), 32'd4);

    req(0, 1'b1, 16'h0010, 16'h5555);
    drain();
    q.delete();
    req(0, 1'b1, 16'h0010, 16'hAAAA);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("no_rsp_after_reset", 0, 32'(q.size()), 32'd0);
    chk("led_cleared", 0, 32'(led[0]), 32'd0);
    req(0, 1'b0, 16'h0010, 16'h0000);
    drain();
    pop(s1);
    chk("aborted_store", 0, 32'(s1.d), 32'h5555);

    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 8; p++) req(i, 1'b1, pool[p], 16'($urandom));
      repeat (80) begin
        k = $urandom_range(0, 12);
        a = k < 8 ? pool[k] : k == 8 ? 16'hFF00 : k == 9 ? 16'hFF01 : k == 10 ? 16'hFF02 :
            k == 11 ? 16'(16'h0100 + $urandom_range(0, 16'hFDFF)) : 16'(16'hFF03 + $urandom_range(0, 252));
        sw = 10'($urandom);
        req(i, 1'($urandom), a, 16'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      drain();
      q.delete();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
